write_module: RTL and testbench

WRITE_MODULE -- requirements
Module: write_module

---
 rtl/write_module.sv | 198 +++++++++++++++++++
 tb/tb_write_module.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_module.sv
`default_nettype none
// ============================================================================
// Module   : write_module
// Purpose  : Write path of an 8-set, 2-way, 16-word-line write-back /
//            write-allocate cache with dirty-victim writeback and line fill.
// Revision : 1.0  initial release
// ============================================================================
module write_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        done,
    output logic        hit,
    output logic        mem_we,
    output logic        mem_re,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t      state_q;
    logic [11:0] addr_q;
    logic [7:0]  wdata_q;
    logic        way_q;
    logic [4:0]  cnt_q;
    logic [7:0]  lru_q;
    logic [6:0]  tag_q  [16];
    logic [7:0]  line_q [256];

    logic [2:0]  idx;
    logic [4:0]  req_tag;
    logic [3:0]  off;
    logic [6:0]  ent0;
    logic [6:0]  ent1;
    logic [6:0]  vict_ent;
    logic [6:0]  way_ent;
    logic        hit0;
    logic        hit1;
    logic        hit_d;
    logic        way_d;
    logic        dirty_d;
    logic [3:0]  word_nxt;
    logic [3:0]  word_prev;
    logic        arr_we;
    logic [7:0]  arr_idx;
    logic [7:0]  arr_wdata;

    assign idx       = addr_q[6:4];
    assign req_tag   = addr_q[11:7];
    assign off       = addr_q[3:0];
    assign ent0      = tag_q[{idx, 1'b0}];
    assign ent1      = tag_q[{idx, 1'b1}];
    assign way_ent   = tag_q[{idx, way_q}];
    assign hit0      = ent0[6] && (ent0[4:0] == req_tag);
    assign hit1      = ent1[6] && (ent1[4:0] == req_tag);
    assign hit_d     = hit0 | hit1;
    assign word_nxt  = cnt_q[3:0] + 4'd1;
    assign word_prev = cnt_q[3:0] - 4'd1;

    // Target way: the matching way on a hit, otherwise the victim
    // (lowest invalid way first, then the LRU pointer).
    always_comb begin
        way_d = 1'b0;
        if (hit_d) begin
            way_d = hit1;
        end else if (!ent0[6]) begin
            way_d = 1'b0;
        end else if (!ent1[6]) begin
            way_d = 1'b1;
        end else begin
            way_d = lru_q[idx];
        end
    end

    assign vict_ent = way_d ? ent1 : ent0;
    assign dirty_d  = vict_ent[6] & vict_ent[5];

    // Line array writes: fill words land one cycle after their read strobe.
    always_comb begin
        arr_we    = 1'b0;
        arr_idx   = 8'd0;
        arr_wdata = 8'd0;
        if ((state_q == S_FILL) && (cnt_q != 5'd0)) begin
            arr_we    = 1'b1;
            arr_idx   = {idx, way_q, word_prev};
            arr_wdata = mem_rdata;
        end else if (state_q == S_WRITE) begin
            arr_we    = 1'b1;
            arr_idx   = {idx, way_q, off};
            arr_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            line_q[arr_idx] <= arr_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_ready <= 1'b1;
            done      <= 1'b0;
            hit       <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= 12'd0;
            mem_wdata <= 8'd0;
            addr_q    <= 12'd0;
            wdata_q   <= 8'd0;
            way_q     <= 1'b0;
            cnt_q     <= 5'd0;
            lru_q     <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                tag_q[i] <= 7'd0;
            end
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_data;
                        req_ready <= 1'b0;
                        state_q   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit   <= hit_d;
                    way_q <= way_d;
                    cnt_q <= 5'd0;
                    if (hit_d) begin
                        state_q <= S_WRITE;
                    end else if (dirty_d) begin
                        state_q   <= S_WB;
                        mem_we    <= 1'b1;
                        mem_addr  <= {vict_ent[4:0], idx, 4'd0};
                        mem_wdata <= line_q[{idx, way_d, 4'd0}];
                    end else begin
                        state_q  <= S_FILL;
                        mem_re   <= 1'b1;
                        mem_addr <= {req_tag, idx, 4'd0};
                    end
                end
                S_WB: begin
                    if (cnt_q[3:0] == 4'd15) begin
                        state_q   <= S_FILL;
                        cnt_q     <= 5'd0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b1;
                        mem_addr  <= {req_tag, idx, 4'd0};
                        mem_wdata <= 8'd0;
                    end else begin
                        cnt_q     <= cnt_q + 5'd1;
                        mem_addr  <= {way_ent[4:0], idx, word_nxt};
                        mem_wdata <= line_q[{idx, way_q, word_nxt}];
                    end
                end
                S_FILL: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd16) begin
                        state_q <= S_WRITE;
                    end else if (cnt_q == 5'd15) begin
                        mem_re   <= 1'b0;
                        mem_addr <= 12'd0;
                    end else begin
                        mem_addr <= {req_tag, idx, word_nxt};
                    end
                end
                S_WRITE: begin
                    tag_q[{idx, way_q}] <= {2'b11, req_tag};
                    lru_q[idx]          <= ~way_q;
                    state_q             <= S_IDLE;
                    req_ready           <= 1'b1;
                    done                <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_module
// Purpose  : Randomised self-checking bench for write_module against a
//            set/way-level cache model and a flat external memory image.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_write_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [11:0] req_addr = 12'd0;
    logic [7:0]  req_data = 8'd0;
    logic        req_ready;
    logic        done;
    logic        hit;
    logic        mem_we;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    always #5 clk = ~clk;

    write_module dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .done      (done),
        .hit       (hit),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // External memory as the DUT sees it, and as the model says it should be.
    logic [7:0]  ext_mem [4096];
    logic [7:0]  ref_mem [4096];

    // Cache model: per set, per way.
    bit          m_valid [8][2];
    bit          m_dirty [8][2];
    logic [4:0]  m_tag   [8][2];
    logic [7:0]  m_line  [8][2][16];
    bit          m_lru   [8];

    // Expected memory bus per cycle: {we, re, addr, wdata}; absent = idle bus.
    logic [31:0] exp_bus [int];

    int n;
    int done_cyc;
    int n_cmp;
    int n_err;
    int n_acc;
    int n_done;
    bit pending;
    bit exp_hit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        pending = 1'b0;
        exp_bus.delete();
    endtask

    task automatic model_accept(input logic [11:0] a, input logic [7:0] d);
        int          s;
        int          t;
        int          way;
        int          hw;
        logic [4:0]  tg;
        logic [11:0] ma;
        s  = int'(a[6:4]);
        tg = a[11:7];
        hw = -1;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[s][w] && (m_tag[s][w] == tg)) hw = w;
        end
        t = n + 2;
        if (hw >= 0) begin
            way      = hw;
            exp_hit  = 1'b1;
            done_cyc = n + 3;
        end else begin
            exp_hit = 1'b0;
            if (!m_valid[s][0])      way = 0;
            else if (!m_valid[s][1]) way = 1;
            else                     way = int'(m_lru[s]);
            if (m_valid[s][way] && m_dirty[s][way]) begin
                for (int w = 0; w < 16; w++) begin
                    ma = {m_tag[s][way], a[6:4], 4'(w)};
                    exp_bus[t + w] = {10'd0, 2'b10, ma, m_line[s][way][w]};
                    ref_mem[ma]    = m_line[s][way][w];
                end
                t += 16;
            end
            for (int w = 0; w < 16; w++) begin
                ma = {tg, a[6:4], 4'(w)};
                exp_bus[t + w]      = {10'd0, 2'b01, ma, 8'h00};
                m_line[s][way][w] = ref_mem[ma];
            end
            done_cyc = t + 18;
        end
        m_line[s][way][a[3:0]] = d;
        m_valid[s][way] = 1'b1;
        m_dirty[s][way] = 1'b1;
        m_tag[s][way]   = tg;
        m_lru[s]        = (way == 0);
        pending = 1'b1;
        n_acc++;
    endtask

    // One clock cycle: check outputs at the falling edge, act as memory,
    // present the next request, then advance to the next falling edge.
    task automatic cycle(input logic v, input logic [11:0] a, input logic [7:0] d);
        logic [31:0] eb;
        logic [7:0]  rd_next;
        bit          dn;
        dn = pending && (n == done_cyc);
        chk("ready", 32'(req_ready), 32'(!(pending && (n < done_cyc))));
        chk("done", 32'(done), 32'(dn));
        if (dn) begin
            chk("hit", 32'(hit), 32'(exp_hit));
            pending = 1'b0;
        end
        if (done) n_done++;
        eb = 32'd0;
        if (exp_bus.exists(n)) begin
            eb = exp_bus[n];
            exp_bus.delete(n);
        end
        chk("membus", {10'd0, mem_we, mem_re, mem_addr, mem_wdata}, eb);
        rd_next = mem_re ? ext_mem[mem_addr] : 8'($urandom);
        if (mem_we) ext_mem[mem_addr] = mem_wdata;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        if (v && !pending) model_accept(a, d);
        @(posedge clk);
        #1;
        mem_rdata = rd_next;
        @(negedge clk);
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 12'($urandom), 8'($urandom));
    endtask

    task automatic wait_done();
        for (int k = 0; (k < 80) && pending; k++) cycle(1'b0, 12'($urandom), 8'($urandom));
    endtask

    task automatic write_req(input logic [11:0] a, input logic [7:0] d);
        cycle(1'b1, a, d);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_hit"}, 32'(hit), 32'd0);
        chk({tag, "_bus"}, {10'd0, mem_we, mem_re, mem_addr, mem_wdata}, 32'd0);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        @(negedge clk);
        n++;
        rst = 1'b0;
    endtask

    initial begin
        int diffs;
        n = 0; n_cmp = 0; n_err = 0; n_acc = 0; n_done = 0;
        done_cyc = 0; exp_hit = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ext_mem[i] = 8'($urandom);
            ref_mem[i] = ext_mem[i];
        end
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        rst = 1'b0;
        idle(2);

        // Clean miss, hit, second-way fill, then dirty eviction of way 0.
        write_req(12'h123, 8'h5A);
        idle(2);
        write_req(12'h125, 8'hA5);
        write_req(12'h1A3, 8'h3C);
        write_req(12'h0A0, 8'h11);
        chk("wb_0x123", 32'(ext_mem[12'h123]), 32'h5A);
        chk("wb_0x125", 32'(ext_mem[12'h125]), 32'hA5);
        // Write into a line that is already dirty.
        write_req(12'h1A7, 8'hC3);
        idle(3);

        // Reset in FILL cycle 8 of a clean miss, then the same address again.
        cycle(1'b1, 12'h745, 8'h66);
        for (int i = 0; i < 8; i++) cycle(1'b0, 12'h000, 8'h00);
        reset_now();
        idle(2);
        write_req(12'h745, 8'h67);
        idle(2);

        // Continuous req_valid with changing addresses over two busy sets.
        n_acc = 0;
        n_done = 0;
        for (int i = 0; i < 1200; i++) begin
            cycle(1'b1, {5'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd5,
                         4'($urandom)}, 8'($urandom));
        end
        // Sparse random traffic over all sets.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 9) < 4), {5'($urandom_range(0, 5)), 3'($urandom), 4'($urandom)},
                  8'($urandom));
        end
        cycle(1'b0, 12'h000, 8'h00);
        wait_done();
        idle(2);
        chk("accepts_vs_dones", 32'(n_done), 32'(n_acc));

        diffs = 0;
        for (int i = 0; i < 4096; i++) begin
            if (ext_mem[i] !== ref_mem[i]) diffs++;
        end
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", n);
        $fatal(1);
    end

endmodule
`default_nettype wire
